// File: rtl/product_bcd_converter.sv
// product_bcd_converter
//
// Converts the 16-bit multiplier product {A,B} into five BCD digits using a
// sequential shift-and-add-3 (double dabble) loop. The displayed result is
// held in dedicated output registers. Those registers only change when a
// conversion completes, so the display never shows a partial value.
//
// Ports
//   Clk      in   1   system clock, rising edge
//   Reset    in   1   asynchronous, active-high; clears all state and outputs
//   Start    in   1   conversion request, sampled only while idle
//   Product  in  16   value to convert
//   Busy     out  1   conversion in progress
//   Done     out  1   one-cycle pulse when Digits/Sign update
//   Sign     out  1   negative result (signed build only, otherwise 0)
//   Digits   out 20   five BCD digits, [19:16] ten-thousands .. [3:0] units
//
// Build option
//   BCD_SIGNED_EN  defined: Product is two's complement. The magnitude is
//                  converted and Sign reports the sign.
//                  undefined: Product is unsigned and Sign is tied to 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for Start; outputs hold the last result
// CONV  | one add-3/shift step per cycle, 16 steps in total
// DONE  | publish bcd to Digits/Sign and pulse Done on the way to IDLE

module product_bcd_converter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Product,
  output logic        Busy,
  output logic        Done,
  output logic        Sign,
  output logic [19:0] Digits
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mag_q, mag_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] digits_q, digits_d;
  logic        done_q, done_d;
  logic [19:0] bcd_adj;
  logic [35:0] shifted;
`ifdef BCD_SIGNED_EN
  logic        sgn_q, sgn_d;
  logic        sign_q, sign_d;
`endif

  always_comb begin
    // Each nibble is corrected independently. A nibble of at most 9 plus 3
    // stays within 4 bits, so no carry crosses into the next digit.
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj[18:0], mag_q, 1'b0};
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    done_d   = 1'b0;
`ifdef BCD_SIGNED_EN
    sgn_d    = sgn_q;
    sign_d   = sign_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          bcd_d   = 20'h00000;
          cnt_d   = 4'd0;
          state_d = ST_CONV;
`ifdef BCD_SIGNED_EN
          sgn_d   = Product[15];
          mag_d   = Product[15] ? (~Product + 16'd1) : Product;
`else
          mag_d   = Product;
`endif
        end
      end
      ST_CONV: begin
        bcd_d = shifted[35:16];
        mag_d = shifted[15:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        digits_d = bcd_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
`ifdef BCD_SIGNED_EN
        sign_d   = sgn_q;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      mag_q    <= 16'h0000;
      bcd_q    <= 20'h00000;
      cnt_q    <= 4'd0;
      digits_q <= 20'h00000;
      done_q   <= 1'b0;
`ifdef BCD_SIGNED_EN
      sgn_q    <= 1'b0;
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      done_q   <= done_d;
`ifdef BCD_SIGNED_EN
      sgn_q    <= sgn_d;
      sign_q   <= sign_d;
`endif
    end
  end

  assign Busy   = (state_q != ST_IDLE);
  assign Done   = done_q;
  assign Digits = digits_q;
`ifdef BCD_SIGNED_EN
  assign Sign   = sign_q;
`else
  assign Sign   = 1'b0;
`endif

endmodule
